shake_output_unpacker: RTL

SHAKE_OUTPUT_UNPACKER -- requirements
Module: shake_output_unpacker

---
 rtl/shake_output_unpacker.sv | 120 ++++++++++++
 1 files changed

// File: rtl/shake_output_unpacker.sv
// Unpacks the 64-bit SHAKE output words held in BRAM into a stream of
// COEFF_W-bit coefficients, little-endian, with a valid/ready handshake.
module shake_output_unpacker #(
    parameter int COEFF_W = 13,
    parameter int ADDR_W  = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  rd_base,
    input  logic [8:0]         coeff_count,
    output logic [ADDR_W-1:0]  rd_address,
    input  logic [63:0]        din,
    output logic [COEFF_W-1:0] coeff,
    output logic               coeff_valid,
    output logic [8:0]         coeff_index,
    input  logic               coeff_ready,
    output logic               busy,
    output logic               done
);

    localparam int ACC_W = 64 + COEFF_W - 1;
    localparam logic [6:0] CW7 = 7'(COEFF_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EMIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  rd_address_q, rd_address_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [6:0]         fill_q, fill_d;
    logic [8:0]         index_q, index_d;
    logic [8:0]         count_q, count_d;
    logic [ACC_W-1:0]   din_ext;

    // A refill only happens with fewer than COEFF_W bits left, so the
    // shifted word always fits inside the accumulator.
    assign din_ext = {{(ACC_W-64){1'b0}}, din};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            rd_address_q <= '0;
            acc_q        <= '0;
            fill_q       <= '0;
            index_q      <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            rd_address_q <= rd_address_d;
            acc_q        <= acc_d;
            fill_q       <= fill_d;
            index_q      <= index_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_address_d = rd_address_q;
        acc_d        = acc_q;
        fill_d       = fill_q;
        index_d      = index_q;
        count_d      = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d      = coeff_count;
                    rd_address_d = rd_base;
                    acc_d        = '0;
                    fill_d       = '0;
                    index_d      = '0;
                    state_d      = (coeff_count == 9'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                acc_d        = acc_q | (din_ext << fill_q);
                fill_d       = fill_q + 7'd64;
                rd_address_d = rd_address_q + 1'b1;
                state_d      = S_EMIT;
            end
            S_EMIT: begin
                if (coeff_ready) begin
                    acc_d   = acc_q >> COEFF_W;
                    fill_d  = fill_q - CW7;
                    index_d = index_q + 9'd1;
                    if (index_q == count_q - 9'd1) begin
                        state_d = S_DONE;
                    end else if (fill_d < CW7) begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                acc_d   = '0;
                fill_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign rd_address  = rd_address_q;
    assign coeff       = acc_q[COEFF_W-1:0];
    assign coeff_valid = (state_q == S_EMIT);
    assign coeff_index = index_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

endmodule
